// File: rtl/note_lane_scroller.sv
// note_lane_scroller: owns the five falling note sprites (green, red, yellow,
// blue, orange). Spawns notes from the chart on each frame tick, scrolls them
// down, judges strums against the strike window, keeps score, and drives the
// per-pixel sprite flags and per-lane positions for color_mapper.
//
// Optional feature: define NOTE_STREAK_EN to enable the hit streak counter and
// streak-based score multiplier. Without it, streak is 0 and every hit is +1.
module note_lane_scroller #(
  parameter int NOTE_SPEED = 2,
  parameter int LANE_X0    = 96,
  parameter int LANE_PITCH = 96,
  parameter int HIT_Y_MIN  = 384,
  parameter int HIT_Y_MAX  = 448,
  parameter int Y_EXIT     = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [4:0]  spawn_mask,
  input  logic [4:0]  fret_keys,
  input  logic        strum,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_sprite_green,
  output logic        is_sprite_red,
  output logic        is_sprite_yellow,
  output logic        is_sprite_blue,
  output logic        is_sprite_orange,
  output logic [9:0]  green_x_pos,
  output logic [9:0]  red_x_pos,
  output logic [9:0]  yellow_x_pos,
  output logic [9:0]  blue_x_pos,
  output logic [9:0]  orange_x_pos,
  output logic [9:0]  green_y_pos,
  output logic [9:0]  red_y_pos,
  output logic [9:0]  yellow_y_pos,
  output logic [9:0]  blue_y_pos,
  output logic [9:0]  orange_y_pos,
  output logic [4:0]  hit,
  output logic [4:0]  miss,
  output logic [15:0] score,
  output logic [7:0]  streak
);

  typedef enum logic {IDLE, FALL} lane_state_t;

  lane_state_t state_q [5];
  lane_state_t state_d [5];
  logic [9:0]  y_q [5];
  logic [9:0]  y_d [5];
  logic [9:0]  lane_x [5];
  logic [10:0] moved [5];
  logic [4:0]  in_window;
  logic [4:0]  hit_d, miss_d, sprite;
  logic [1:0]  frame_sync;
  logic        frame_prev;
  logic        tick;
  logic [2:0]  hit_count;
  logic [4:0]  score_add;
  logic [16:0] score_sum;
  logic [15:0] score_q, score_d;
  logic [7:0]  streak_q, streak_d;
  logic [4:0]  hit_q, miss_q;
`ifdef NOTE_STREAK_EN
  logic [8:0]  streak_sum;
  logic [7:0]  streak_inc;
  logic [2:0]  bonus;
`endif

  // Bring the vsync strobe into the Clk domain and keep the previous level for edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_sync <= '0;
      frame_prev <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[0], frame_clk};
      frame_prev <= frame_sync[1];
    end
  end

  assign tick = frame_sync[1] & ~frame_prev;

  // Fixed lane left edges; 11-bit per-lane moved y and strike-window test on the pre-tick y
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lane_x[i]    = 10'(LANE_X0 + i * LANE_PITCH);
      moved[i]     = {1'b0, y_q[i]} + 11'(NOTE_SPEED);
      in_window[i] = (state_q[i] == FALL) &&
                     ({1'b0, y_q[i]} >= 11'(HIT_Y_MIN)) &&
                     ({1'b0, y_q[i]} <= 11'(HIT_Y_MAX));
    end
  end

  // Per-lane next state: a hit wins over move/spawn; exit and overstrum share one miss bit
  always_comb begin
    hit_d  = '0;
    miss_d = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      y_d[i]     = y_q[i];
      if (strum && fret_keys[i] && in_window[i]) begin
        state_d[i] = IDLE;
        y_d[i]     = '0;
        hit_d[i]   = 1'b1;
      end else begin
        if (strum && fret_keys[i]) begin
          miss_d[i] = 1'b1;
        end
        if (tick) begin
          if (state_q[i] == FALL) begin
            if (moved[i] >= 11'(Y_EXIT)) begin
              state_d[i] = IDLE;
              y_d[i]     = '0;
              miss_d[i]  = 1'b1;
            end else begin
              y_d[i] = moved[i][9:0];
            end
          end else if (spawn_mask[i]) begin
            state_d[i] = FALL;
            y_d[i]     = '0;
          end
        end
      end
    end
  end

  // Score and streak update; the bonus is based on the streak after this cycle's hits
  always_comb begin
    hit_count = '0;
    for (int i = 0; i < 5; i++) begin
      hit_count = hit_count + 3'(hit_d[i]);
    end
`ifdef NOTE_STREAK_EN
    streak_sum = {1'b0, streak_q} + 9'(hit_count);
    streak_inc = streak_sum[8] ? 8'hFF : streak_sum[7:0];
    bonus      = 3'd1 + 3'(streak_inc >= 8'd10) + 3'(streak_inc >= 8'd20) + 3'(streak_inc >= 8'd30);
    score_add  = 5'(hit_count) * 5'(bonus);
    streak_d   = (|miss_d) ? 8'd0 : streak_inc;
`else
    score_add  = 5'(hit_count);
    streak_d   = 8'd0;
`endif
    score_sum = {1'b0, score_q} + 17'(score_add);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Lane, pulse and score registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= IDLE;
        y_q[i]     <= '0;
      end
      hit_q    <= '0;
      miss_q   <= '0;
      score_q  <= '0;
      streak_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        y_q[i]     <= y_d[i];
      end
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      streak_q <= streak_d;
    end
  end

  // Pixel-in-sprite test with 11-bit bounds so x+63 and y+63 never wrap
  always_comb begin
    sprite = '0;
    for (int i = 0; i < 5; i++) begin
      sprite[i] = (state_q[i] == FALL) &&
                  ({1'b0, DrawX} >= {1'b0, lane_x[i]}) &&
                  ({1'b0, DrawX} <= ({1'b0, lane_x[i]} + 11'd63)) &&
                  ({1'b0, DrawY} >= {1'b0, y_q[i]}) &&
                  ({1'b0, DrawY} <= ({1'b0, y_q[i]} + 11'd63));
    end
  end

  assign is_sprite_green  = sprite[0];
  assign is_sprite_red    = sprite[1];
  assign is_sprite_yellow = sprite[2];
  assign is_sprite_blue   = sprite[3];
  assign is_sprite_orange = sprite[4];
  assign green_x_pos      = lane_x[0];
  assign red_x_pos        = lane_x[1];
  assign yellow_x_pos     = lane_x[2];
  assign blue_x_pos       = lane_x[3];
  assign orange_x_pos     = lane_x[4];
  assign green_y_pos      = y_q[0];
  assign red_y_pos        = y_q[1];
  assign yellow_y_pos     = y_q[2];
  assign blue_y_pos       = y_q[3];
  assign orange_y_pos     = y_q[4];
  assign hit              = hit_q;
  assign miss             = miss_q;
  assign score            = score_q;
  assign streak           = streak_q;

endmodule

// File: doc/note_lane_scroller.md
# note_lane_scroller

Upstream producer for `color_mapper`. It owns the five falling note sprites (green, red, yellow, blue, orange lanes), which are 64×64 pixels each. Per frame it spawns notes from the chart, scrolls them down, and resolves strums against the strike window. Per pixel it drives the `is_sprite_*` flags and the per-lane `*_x_pos`/`*_y_pos` that `color_mapper` uses to address the sprite frame RAMs.

## Interface
Parameters:
- `NOTE_SPEED`, 2: pixels added to y per frame tick.
- `LANE_X0`, 96: x position of the green lane's left edge.
- `LANE_PITCH`, 96: x spacing between lanes.
- `HIT_Y_MIN`, 384: lowest y (inclusive) counted as a hit.
- `HIT_Y_MAX`, 448: highest y (inclusive) counted as a hit.
- `Y_EXIT`, 480: a note whose new y is at or beyond this value has left the screen.

Ports:
- `Clk`, in, 1: system clock. All state is on its rising edge.
- `Reset`, in, 1: asynchronous, active-high. Clears all state immediately.
- `frame_clk`, in, 1: VGA vsync-derived frame strobe. It is asynchronous to `Clk` and is synchronized internally.
- `spawn_mask`, in, 5: chart notes for the current frame, bit order [orange, blue, yellow, red, green], with green = bit 0.
- `fret_keys`, in, 5: fret buttons held, same bit order, synchronous to `Clk`.
- `strum`, in, 1: single-cycle strum pulse, synchronous to `Clk`.
- `DrawX`, `DrawY`, in, 10 each: current pixel coordinates.
- `is_sprite_green`, `is_sprite_red`, `is_sprite_yellow`, `is_sprite_blue`, `is_sprite_orange`, out, 1 each: current pixel lies inside that lane's active note.
- `green_x_pos` … `orange_x_pos`, out, 10 each: lane x constants, `LANE_X0 + i*LANE_PITCH`.
- `green_y_pos` … `orange_y_pos`, out, 10 each: note top edge.
- `hit`, out, 5: one-cycle pulse per lane on a successful hit.
- `miss`, out, 5: one-cycle pulse per lane on a missed or overstrummed note.
- `score`, out, 16: accumulated score.
- `streak`, out, 8: current hit streak.

## Operation
- **Frame tick.** `frame_clk` passes through a 2-flop synchronizer, then a rising-edge detect. The result is `tick`, a one-`Clk` pulse, exactly once per `frame_clk` rising edge.
- **Per-lane states.** Each lane is `IDLE` or `FALL`. It holds a 10-bit `y`.
- **Spawn.** On `tick`, for each lane in `IDLE` with its `spawn_mask` bit set: the lane goes to `FALL` with `y=0`. A set mask bit on a lane already in `FALL` is ignored.
- **Move.** On `tick`, each lane in `FALL` computes `y+NOTE_SPEED` in 11-bit arithmetic.
  - If the result is ≥ `Y_EXIT`: the lane goes to `IDLE`, `y=0`, and its `miss` bit pulses.
  - Otherwise `y` takes the new value.
- **Strum.** On `strum`, for each lane with its `fret_keys` bit set:
  - If the lane is in `FALL` with `HIT_Y_MIN ≤ y ≤ HIT_Y_MAX`: the lane goes to `IDLE`, `y=0`, its `hit` bit pulses, and score is added.
  - Otherwise its `miss` bit pulses (overstrum) and the lane's state is unchanged.
  - Lanes whose fret is not held are unaffected.
- **Score.**
  - +1 per hit; the per-hit add is summed across simultaneous hits.
  - Saturates at 0xFFFF.
- **Sprite flags.** Combinational:
  - Condition: lane in `FALL`, `x ≤ DrawX ≤ x+63`, and `y ≤ DrawY ≤ y+63`.
  - Comparisons use 11-bit sums so there is no wrap.
- **Outputs after reset.**
  - All lanes `IDLE`, so all `is_sprite_*` are 0.
  - All `y_pos` = 0; the `x_pos` outputs are constants.
  - `hit`, `miss`, `score` and `streak` are all 0.

## Timing
- `tick` is asserted 2–3 `Clk` cycles after `frame_clk` rises. `y_pos` changes on the `Clk` edge that ends the `tick` cycle.
- A hit or overstrum takes effect on the edge ending the `strum` cycle. `hit`, `miss` and `score` are registered and visible in the next cycle.
- **`strum` and `tick` in the same cycle:**
  - The strike window is judged on the pre-tick `y`.
  - A lane that is hit goes to `IDLE` and is not moved.
  - A spawn for that lane in the same cycle is ignored.
  - Other lanes move or spawn normally.
- **Exit and overstrum on the same lane in the same cycle:** a single `miss` pulse.
- **`Reset` asserted mid-fall:** everything clears asynchronously. The first `tick` after release is handled normally.
- **Sprite flags:** zero-latency combinational from `DrawX`/`DrawY` and the registered `y`.

## Configuration
- `NOTE_STREAK_EN` defined:
  - `streak` increments on each hit cycle (by the number of lanes hit) and saturates at 255.
  - Any `miss` pulse clears it.
  - Per-hit score add = 1 + (`streak`≥10) + (`streak`≥20) + (`streak`≥30), using the post-increment `streak`.
- `NOTE_STREAK_EN` undefined:
  - `streak` is tied to 0.
  - Score adds exactly 1 per hit.

## Test plan
- **Spawn and scroll.** Reset, then `spawn_mask=5'b00001` on one tick, then 10 more ticks → `green_y_pos=20`. With `DrawX=100`, `DrawY=50` → `is_sprite_green=1`; with `DrawY=84` → 0.
- **Hit.** Spawn yellow, 200 ticks → `y=400`. `strum` with `fret_keys=5'b00100` → `hit=5'b00100` for one cycle, `score=1`, yellow `IDLE`, `is_sprite_yellow=0`.
- **Exit miss.** Spawn blue with no strum → on tick 240, `miss[3]` pulses once, lane `IDLE`, `blue_y_pos=0`. Spawn on the active lane at tick 100 → `y` path unchanged.
- **Simultaneous strum and tick.** Red at `y=448`, `strum` + `fret_keys[1]` in the same cycle as `tick` → hit counted, `red_y_pos=0`, no exit miss.
- **Overstrum and streak.** `NOTE_STREAK_EN` defined: 12 consecutive single hits → `score=15`, `streak=12`. Then overstrum orange with no note → `miss[4]` pulses, `streak=0`. With the macro undefined, the 12 hits give `score=12`.
- **Reset mid-operation.** Assert `Reset` with three lanes falling → all flags, `y` and score at 0 within the same cycle. The first tick after release moves nothing.
